anton_neopixel_frame_sequencer: RTL

Frame sequencer for the NeoPixel controller. Sits between the register/buffer block and the output pin. When software sets the run bit, it walks the pixel buffer byte by byte and serialises each byte MSB-first as WS2812 bit waveforms. It then holds the line low for the latch (reset) gap and pulses `stream_sync_of` so the register block can clear or keep `reg_ctrl_run` according to `reg_ctrl_loop`.

---
 rtl/anton_neopixel_frame_sequencer_pkg.sv | 32 +++
 rtl/anton_neopixel_bit_timer.sv | 32 +++
 rtl/anton_neopixel_frame_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/anton_neopixel_frame_sequencer_pkg.sv
// Shared definitions for the NeoPixel frame sequencer: timing defaults,
// FSM state encoding and constant helper functions.
package anton_neopixel_frame_sequencer_pkg;

  localparam int BUFFER_END_DEFAULT = 255;
  localparam int T0H_DEFAULT        = 17;
  localparam int T1H_DEFAULT        = 35;
  localparam int T_BIT_DEFAULT      = 62;
  localparam int T_RESET_DEFAULT    = 2500;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BIT_HIGH = 2'd1,
    ST_BIT_LOW  = 2'd2,
    ST_LATCH    = 2'd3
  } fsm_state_e;

  // Ceiling log2, never below 1 so a degenerate range still gets a real bus.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// Loadable down-counter shared by the bit-high, bit-low and latch phases;
// o_tc is asserted while the count sits at zero.
module anton_neopixel_bit_timer #(
  parameter int TW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_tc,
  output logic [TW-1:0] o_count
);

  logic [TW-1:0] r_count;

  // Count register: load wins, otherwise count down and park at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {TW{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != {TW{1'b0}}) begin
      r_count <= r_count - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc    = (r_count == {TW{1'b0}});
  assign o_count = r_count;

endmodule

// File: rtl/anton_neopixel_frame_sequencer.sv
// Walks the pixel buffer and serialises each byte MSB-first as WS2812 bit
// waveforms, followed by a latch gap and a one-cycle end-of-frame pulse.
module anton_neopixel_frame_sequencer
  import anton_neopixel_frame_sequencer_pkg::*;
#(
  parameter  int BUFFER_END  = BUFFER_END_DEFAULT,
  parameter  int T0H         = T0H_DEFAULT,
  parameter  int T1H         = T1H_DEFAULT,
  parameter  int T_BIT       = T_BIT_DEFAULT,
  parameter  int T_RESET     = T_RESET_DEFAULT,
  localparam int BUFFER_BITS = clog2_min1(BUFFER_END + 1)
) (
  input  logic                   busClk,
  input  logic                   busReset,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_init,
  input  logic                   reg_ctrl_limit,
  input  logic                   reg_ctrl_32bit,
  input  logic [12:0]            reg_max,
  output logic [BUFFER_BITS-1:0] pixel_addr,
  input  logic [7:0]             pixel_byte,
  output logic                   neoData,
  output logic                   state,
  output logic                   stream_sync_of
);

  localparam int TW = clog2_min1(max_int(T_BIT, T_RESET) + 1);

  fsm_state_e             r_state;
  fsm_state_e             w_state_next;
  logic [BUFFER_BITS-1:0] r_addr, w_addr_next;
  logic [BUFFER_BITS-1:0] r_end, w_end_next;
  logic [BUFFER_BITS-1:0] w_end_calc, w_addr_adv;
  logic [12:0]            w_end_wide, w_addr_wide;
  logic [7:0]             r_shift, w_shift_next;
  logic [2:0]             r_bit, w_bit_next;
  logic                   r_mode32, w_mode32_next;
  logic                   r_last, w_last_next;
  logic                   r_neo, r_busy, r_sync, w_sync_next;
  logic                   w_timer_load, w_tc;
  logic [TW-1:0]          w_timer_val, w_count;

  function automatic logic [TW-1:0] high_load(input logic b);
    return b ? TW'(T1H - 1) : TW'(T0H - 1);
  endfunction

  function automatic logic [TW-1:0] low_load(input logic b);
    return b ? TW'(T_BIT - T1H - 1) : TW'(T_BIT - T0H - 1);
  endfunction

  anton_neopixel_bit_timer #(.TW(TW)) u_timer (
    .i_clk      (busClk),
    .i_rst      (busReset),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_tc       (w_tc),
    .o_count    (w_count)
  );

  // Last byte index for a new frame: clamp to the buffer, skip 32-bit padding.
  always_comb begin
    if (reg_ctrl_limit && (reg_max <= 13'(BUFFER_END))) begin
      w_end_wide = reg_max;
    end else begin
      w_end_wide = 13'(BUFFER_END);
    end
    if (reg_ctrl_32bit && (w_end_wide[1:0] == 2'b11)) begin
      w_end_wide = w_end_wide - 13'd1;
    end else begin
      w_end_wide = w_end_wide;
    end
    w_end_calc = w_end_wide[BUFFER_BITS-1:0];
  end

  // Next byte address, stepping over the padding byte of each 32-bit word.
  always_comb begin
    w_addr_wide = 13'(r_addr) + 13'd1;
    if (r_mode32 && (w_addr_wide[1:0] == 2'b11)) begin
      w_addr_wide = w_addr_wide + 13'd1;
    end else begin
      w_addr_wide = w_addr_wide;
    end
    w_addr_adv = w_addr_wide[BUFFER_BITS-1:0];
  end

  // Next-state logic. The address advances when the high phase of bit 0
  // ends, so the combinational buffer read is settled by the time the
  // following byte is loaded at the end of the bit.
  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_end_next    = r_end;
    w_mode32_next = r_mode32;
    w_shift_next  = r_shift;
    w_bit_next    = r_bit;
    w_last_next   = r_last;
    w_sync_next   = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_val   = {TW{1'b0}};
    if (reg_ctrl_init) begin
      w_state_next = ST_IDLE;
      w_addr_next  = {BUFFER_BITS{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (reg_ctrl_run) begin
            w_state_next  = ST_BIT_HIGH;
            w_end_next    = w_end_calc;
            w_mode32_next = reg_ctrl_32bit;
            w_shift_next  = pixel_byte;
            w_bit_next    = 3'd7;
            w_last_next   = 1'b0;
            w_timer_load  = 1'b1;
            w_timer_val   = high_load(pixel_byte[7]);
          end else begin
            w_addr_next = {BUFFER_BITS{1'b0}};
          end
        end
        ST_BIT_HIGH: begin
          if (w_tc) begin
            w_state_next = ST_BIT_LOW;
            w_timer_load = 1'b1;
            w_timer_val  = low_load(r_shift[7]);
            if (r_bit != 3'd0) begin
              w_last_next = r_last;
            end else if (r_addr == r_end) begin
              w_last_next = 1'b1;
            end else begin
              w_addr_next = w_addr_adv;
            end
          end else begin
            w_state_next = ST_BIT_HIGH;
          end
        end
        ST_BIT_LOW: begin
          if (!w_tc) begin
            w_state_next = ST_BIT_LOW;
          end else if (r_bit != 3'd0) begin
            w_state_next = ST_BIT_HIGH;
            w_bit_next   = r_bit - 3'd1;
            w_shift_next = {r_shift[6:0], 1'b0};
            w_timer_load = 1'b1;
            w_timer_val  = high_load(r_shift[6]);
          end else if (r_last) begin
            w_state_next = ST_LATCH;
            w_timer_load = 1'b1;
            w_timer_val  = TW'(T_RESET - 1);
            w_sync_next  = (T_RESET == 1);
          end else begin
            w_state_next = ST_BIT_HIGH;
            w_shift_next = pixel_byte;
            w_bit_next   = 3'd7;
            w_timer_load = 1'b1;
            w_timer_val  = high_load(pixel_byte[7]);
          end
        end
        ST_LATCH: begin
          if (w_tc) begin
            w_state_next = ST_IDLE;
            w_addr_next  = {BUFFER_BITS{1'b0}};
          end else begin
            w_sync_next = (w_count == TW'(1));
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_addr_next  = {BUFFER_BITS{1'b0}};
        end
      endcase
    end
  end

  // State, datapath and registered pin outputs.
  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      r_state  <= ST_IDLE;
      r_addr   <= {BUFFER_BITS{1'b0}};
      r_end    <= {BUFFER_BITS{1'b0}};
      r_mode32 <= 1'b0;
      r_shift  <= 8'h00;
      r_bit    <= 3'd0;
      r_last   <= 1'b0;
      r_neo    <= 1'b0;
      r_busy   <= 1'b0;
      r_sync   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_end    <= w_end_next;
      r_mode32 <= w_mode32_next;
      r_shift  <= w_shift_next;
      r_bit    <= w_bit_next;
      r_last   <= w_last_next;
      r_neo    <= (w_state_next == ST_BIT_HIGH);
      r_busy   <= (w_state_next != ST_IDLE);
      r_sync   <= w_sync_next;
    end
  end

  assign pixel_addr     = r_addr;
  assign neoData        = r_neo;
  assign state          = r_busy;
  assign stream_sync_of = r_sync;

endmodule
